// File: rtl/axi_probe_pkg.sv
// axi_probe_pkg: shared error indices and AXI constants for the probe monitor
package axi_probe_pkg;
  typedef enum logic [2:0] {
    ERR_WLAST,
    ERR_W_NO_AW,
    ERR_B_ORPHAN,
    ERR_RLAST,
    ERR_R_NO_AR,
    ERR_STABLE,
    ERR_OVF
  } err_idx_e;
  localparam int ERR_W = 7;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

// File: rtl/axi_probe_monitor_len_fifo.sv
// axi_probe_len_fifo: circular FIFO with occupancy; push on full is dropped unless a pop frees the slot
module axi_probe_len_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & (!full | pop);
  assign do_pop = pop & !empty;
  assign dout = mem[rp];
  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= do_push ? wp + AW'(1) : wp;
      rp <= do_pop ? rp + AW'(1) : rp;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  // Storage needs no reset; occupancy gates every read that matters
  always_ff @(posedge clk)
    if (do_push && !clr) mem[wp] <= din;
endmodule

// File: rtl/axi_probe_monitor.sv
// axi_probe_monitor: passive AXI4 link observer with burst tracking and sticky protocol errors; AXI_PROBE_LAT_EN adds wr_lat_max
module axi_probe_monitor
  import axi_probe_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int OUTST_DEPTH = 4,
  parameter int CNT_W = 16,
  localparam int OW = $clog2(OUTST_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  input  logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  input  logic                bready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  input  logic                rready,
  output logic [CNT_W-1:0]    wr_burst_cnt,
  output logic [CNT_W-1:0]    rd_burst_cnt,
  output logic [OW-1:0]       wr_outst,
  output logic [OW-1:0]       rd_outst,
  output logic [ERR_W-1:0]    err_vec,
  output logic                err_pulse
`ifdef AXI_PROBE_LAT_EN
  ,
  output logic [CNT_W-1:0]    wr_lat_max
`endif
);
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, b_ok;
  logic aw_empty, aw_full, ar_empty, ar_full;
  logic [7:0] aw_head, ar_head, w_beat, r_beat, w_len, r_len;
  logic w_ok, r_ok, w_close, r_close, aw_push, aw_pop, ar_push, ar_pop;
  logic [OW-1:0] pend_b;
  logic [ERR_W-1:0] ev;
  logic aw_hold, w_hold, ar_hold;
  logic [ADDR_W+12:0] aw_pl, aw_pl_q, ar_pl, ar_pl_q;
  logic [DATA_W+DATA_W/8:0] w_pl, w_pl_q;
  logic unused_ok;
  assign unused_ok = ^{bresp, rdata, rresp};
  axi_probe_len_fifo #(.DEPTH(OUTST_DEPTH), .WIDTH(8)) u_aw_q (
    .clk(clk), .reset(reset), .clr(clr), .push(aw_push), .pop(aw_pop), .din(awlen),
    .dout(aw_head), .full(aw_full), .empty(aw_empty), .count(wr_outst)
  );
  axi_probe_len_fifo #(.DEPTH(OUTST_DEPTH), .WIDTH(8)) u_ar_q (
    .clk(clk), .reset(reset), .clr(clr), .push(ar_push), .pop(ar_pop), .din(arlen),
    .dout(ar_head), .full(ar_full), .empty(ar_empty), .count(rd_outst)
  );
  // Handshakes, empty-queue bypass of a same-cycle address, burst closure and error events
  always_comb begin
    aw_hs = awvalid & awready;
    w_hs = wvalid & wready;
    b_hs = bvalid & bready;
    ar_hs = arvalid & arready;
    r_hs = rvalid & rready;
    w_len = aw_empty ? awlen : aw_head;
    r_len = ar_empty ? arlen : ar_head;
    w_ok = w_hs & (!aw_empty | aw_hs);
    r_ok = r_hs & (!ar_empty | ar_hs);
    w_close = w_ok & (w_beat == w_len);
    r_close = r_ok & (r_beat == r_len);
    aw_push = aw_hs & !(w_close & aw_empty);
    ar_push = ar_hs & !(r_close & ar_empty);
    aw_pop = w_close & !aw_empty;
    ar_pop = r_close & !ar_empty;
    b_ok = b_hs & (pend_b != '0);
    aw_pl = {awaddr, awlen, awsize, awburst};
    ar_pl = {araddr, arlen, arsize, arburst};
    w_pl = {wdata, wstrb, wlast};
    ev = '0;
    ev[ERR_WLAST] = w_ok & (wlast != (w_beat == w_len));
    ev[ERR_W_NO_AW] = w_hs & aw_empty & !aw_hs;
    ev[ERR_B_ORPHAN] = b_hs & (pend_b == '0);
    ev[ERR_RLAST] = r_ok & (rlast != (r_beat == r_len));
    ev[ERR_R_NO_AR] = r_hs & ar_empty & !ar_hs;
    ev[ERR_STABLE] = (aw_hold & (!awvalid | aw_pl != aw_pl_q)) | (w_hold & (!wvalid | w_pl != w_pl_q)) | (ar_hold & (!arvalid | ar_pl != ar_pl_q));
    ev[ERR_OVF] = (aw_push & aw_full & !aw_pop) | (ar_push & ar_full & !ar_pop);
  end
  // Remember stalled channels and their payloads for next-cycle stability checks
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      aw_hold <= 1'b0;
      w_hold <= 1'b0;
      ar_hold <= 1'b0;
      aw_pl_q <= '0;
      w_pl_q <= '0;
      ar_pl_q <= '0;
    end else begin
      aw_hold <= awvalid & !awready;
      w_hold <= wvalid & !wready;
      ar_hold <= arvalid & !arready;
      aw_pl_q <= aw_pl;
      w_pl_q <= w_pl;
      ar_pl_q <= ar_pl;
    end
  // Beat counters, pending write responses, saturating burst counters and sticky errors
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      w_beat <= '0;
      r_beat <= '0;
      pend_b <= '0;
      wr_burst_cnt <= '0;
      rd_burst_cnt <= '0;
      err_vec <= '0;
      err_pulse <= 1'b0;
    end else if (clr) begin
      w_beat <= '0;
      r_beat <= '0;
      pend_b <= '0;
      wr_burst_cnt <= '0;
      rd_burst_cnt <= '0;
      err_vec <= '0;
      err_pulse <= 1'b0;
    end else begin
      w_beat <= w_close ? '0 : w_ok ? w_beat + 8'd1 : w_beat;
      r_beat <= r_close ? '0 : r_ok ? r_beat + 8'd1 : r_beat;
      pend_b <= (w_close && !b_ok && pend_b != OW'(OUTST_DEPTH)) ? pend_b + OW'(1) : (b_ok && !w_close) ? pend_b - OW'(1) : pend_b;
      wr_burst_cnt <= (b_ok && !(&wr_burst_cnt)) ? wr_burst_cnt + CNT_W'(1) : wr_burst_cnt;
      rd_burst_cnt <= (r_close && !(&rd_burst_cnt)) ? rd_burst_cnt + CNT_W'(1) : rd_burst_cnt;
      err_vec <= err_vec | ev;
      err_pulse <= |ev;
    end
`ifdef AXI_PROBE_LAT_EN
  logic [CNT_W-1:0] now, ts_head, lat;
  logic ts_empty, unused_ts_full;
  logic [OW-1:0] unused_ts_cnt;
  assign lat = now - ts_head;
  axi_probe_len_fifo #(.DEPTH(OUTST_DEPTH), .WIDTH(CNT_W)) u_ts_q (
    .clk(clk), .reset(reset), .clr(clr), .push(aw_hs), .pop(b_ok & !ts_empty), .din(now),
    .dout(ts_head), .full(unused_ts_full), .empty(ts_empty), .count(unused_ts_cnt)
  );
  // Free-running timestamp and worst AW-to-B latency
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      now <= '0;
      wr_lat_max <= '0;
    end else if (clr) begin
      now <= '0;
      wr_lat_max <= '0;
    end else begin
      now <= now + CNT_W'(1);
      wr_lat_max <= (b_ok && !ts_empty && lat > wr_lat_max) ? lat : wr_lat_max;
    end
`endif
endmodule

// File: tb/tb_axi_probe_monitor.sv
// tb_axi_probe_monitor: directed plan plus random traffic scored against a queue-based protocol model
module tb_axi_probe_monitor;
  localparam int DEPTH = 4, CW = 4, OW = 3, CMAX = 15;
  logic clk = 1'b0, reset = 1'b1, clr = 1'b0;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic [3:0] wstrb;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [CW-1:0] wr_burst_cnt, rd_burst_cnt;
  logic [OW-1:0] wr_outst, rd_outst;
  logic [6:0] err_vec;
  logic err_pulse;
`ifdef AXI_PROBE_LAT_EN
  logic [CW-1:0] wr_lat_max;
`endif
  typedef struct packed {
    logic [CW-1:0] wc;
    logic [CW-1:0] rc;
    logic [OW-1:0] wo;
    logic [OW-1:0] ro;
    logic [6:0] ev;
    logic p;
  } exp_t;
  exp_t expq[$];
  int checks = 0, failures = 0;
  int awq[$], arq[$];
  int wbeat, rbeat, pend, wrc, rdc;
  logic [6:0] m_err;
  logic m_pulse;
  bit aw_st, w_st, ar_st;
  logic [44:0] aw_pp, ar_pp;
  logic [36:0] w_pp;

  axi_probe_monitor #(.ADDR_W(32), .DATA_W(32), .OUTST_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .wr_burst_cnt(wr_burst_cnt), .rd_burst_cnt(rd_burst_cnt), .wr_outst(wr_outst), .rd_outst(rd_outst),
    .err_vec(err_vec), .err_pulse(err_pulse)
`ifdef AXI_PROBE_LAT_EN
    , .wr_lat_max(wr_lat_max)
`endif
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", n, act, req);
    end
  endfunction

  // Reference model: one call per clock, describing the state after the coming edge
  task automatic model();
    logic [6:0] ev;
    bit awh, wh, bh, arh, rh, wcl, rcl, we, re;
    int len;
    ev = '0;
    awh = awvalid && awready;
    wh = wvalid && wready;
    bh = bvalid && bready;
    arh = arvalid && arready;
    rh = rvalid && rready;
    if (reset) begin
      awq.delete(); arq.delete();
      wbeat = 0; rbeat = 0; pend = 0; wrc = 0; rdc = 0; m_err = '0; m_pulse = 1'b0;
      aw_st = 0; w_st = 0; ar_st = 0;
    end else begin
      if (aw_st && (!awvalid || {awaddr, awlen, awsize, awburst} != aw_pp)) ev[5] = 1'b1;
      if (w_st && (!wvalid || {wdata, wstrb, wlast} != w_pp)) ev[5] = 1'b1;
      if (ar_st && (!arvalid || {araddr, arlen, arsize, arburst} != ar_pp)) ev[5] = 1'b1;
      wcl = 0; we = awq.size() == 0;
      if (wh) begin
        if (we && !awh) ev[1] = 1'b1;
        else begin
          len = we ? int'(awlen) : awq[0];
          if (wlast != (wbeat == len)) ev[0] = 1'b1;
          if (wbeat == len) begin wcl = 1; wbeat = 0; end else wbeat++;
        end
      end
      if (wcl && !we) void'(awq.pop_front());
      if (awh && !(wcl && we)) begin
        if (awq.size() < DEPTH) awq.push_back(int'(awlen)); else ev[6] = 1'b1;
      end
      if (bh) begin
        if (pend == 0) ev[2] = 1'b1;
        else begin pend--; if (wrc < CMAX) wrc++; end
      end
      if (wcl && pend < DEPTH) pend++;
      rcl = 0; re = arq.size() == 0;
      if (rh) begin
        if (re && !arh) ev[4] = 1'b1;
        else begin
          len = re ? int'(arlen) : arq[0];
          if (rlast != (rbeat == len)) ev[3] = 1'b1;
          if (rbeat == len) begin rcl = 1; rbeat = 0; end else rbeat++;
        end
      end
      if (rcl && !re) void'(arq.pop_front());
      if (arh && !(rcl && re)) begin
        if (arq.size() < DEPTH) arq.push_back(int'(arlen)); else ev[6] = 1'b1;
      end
      if (rcl && rdc < CMAX) rdc++;
      if (clr) begin
        awq.delete(); arq.delete();
        wbeat = 0; rbeat = 0; pend = 0; wrc = 0; rdc = 0; m_err = '0; m_pulse = 1'b0;
      end else begin
        m_err = m_err | ev;
        m_pulse = |ev;
      end
      aw_st = awvalid && !awready;
      w_st = wvalid && !wready;
      ar_st = arvalid && !arready;
      aw_pp = {awaddr, awlen, awsize, awburst};
      w_pp = {wdata, wstrb, wlast};
      ar_pp = {araddr, arlen, arsize, arburst};
    end
    expq.push_back('{wc: CW'(wrc), rc: CW'(rdc), wo: OW'(awq.size()), ro: OW'(arq.size()), ev: m_err, p: m_pulse});
  endtask

  task automatic step();
    model();
    @(negedge clk);
  endtask

  task automatic idle();
    clr = 0;
    awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 0; awready = 0;
    wdata = '0; wstrb = '0; wlast = 0; wvalid = 0; wready = 0;
    bresp = '0; bvalid = 0; bready = 0;
    araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 0; arready = 0;
    rdata = '0; rresp = '0; rlast = 0; rvalid = 0; rready = 0;
  endtask

  // Scoreboard monitor: every clock the DUT presents a new output set to compare
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("wr_burst_cnt", wr_burst_cnt, e.wc);
      chk("rd_burst_cnt", rd_burst_cnt, e.rc);
      chk("wr_outst", wr_outst, e.wo);
      chk("rd_outst", rd_outst, e.ro);
      chk("err_vec", err_vec, e.ev);
      chk("err_pulse", err_pulse, e.p);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    reset = 1; step(); step();
    chk("reset_err_vec", err_vec, 0);
    chk("reset_wr_outst", wr_outst, 0);
    reset = 0; step();
    // AW len=3, four beats, B
    awvalid = 1; awready = 1; awlen = 3; awaddr = 32'h40; step(); idle();
    for (int i = 0; i < 4; i++) begin
      wvalid = 1; wready = 1; wlast = (i == 3); wdata = $urandom; wstrb = 4'hf; step();
    end
    idle(); bvalid = 1; bready = 1; step(); idle();
    chk("p1_wr_cnt", wr_burst_cnt, 1);
    chk("p1_wr_outst", wr_outst, 0);
    chk("p1_err", err_vec, 0);
    // AR len=1, early rlast
    arvalid = 1; arready = 1; arlen = 1; step(); idle();
    rvalid = 1; rready = 1; rlast = 1; step();
    chk("p2_rlast_err", err_vec, 7'b0001000);
    chk("p2_pulse", err_pulse, 1);
    chk("p2_rd_cnt_early", rd_burst_cnt, 0);
    step(); idle();
    chk("p2_rd_cnt", rd_burst_cnt, 1);
    chk("p2_pulse_gone", err_pulse, 0);
    // five AWs into a depth-4 queue
    clr = 1; step(); idle();
    chk("clr_err", err_vec, 0);
    chk("clr_rd_cnt", rd_burst_cnt, 0);
    awvalid = 1; awready = 1;
    for (int i = 0; i < 4; i++) step();
    chk("p3_no_ovf_yet", err_vec, 0);
    step(); idle();
    chk("p3_wr_outst", wr_outst, 4);
    chk("p3_ovf", err_vec, 7'b1000000);
    // unstable AW payload, then orphan B
    clr = 1; step(); idle();
    awvalid = 1; awaddr = 32'h100; step();
    awaddr = 32'h104; step(); idle();
    chk("p4_stable", err_vec, 7'b0100000);
    bvalid = 1; bready = 1; step(); idle();
    chk("p4_orphan", err_vec, 7'b0100100);
    // bypassed single-beat burst
    clr = 1; step(); idle();
    awvalid = 1; awready = 1; awlen = 0; wvalid = 1; wready = 1; wlast = 1; step(); idle();
    chk("p5_err", err_vec, 0);
    chk("p5_wr_outst", wr_outst, 0);
    bvalid = 1; bready = 1; step(); idle();
    chk("p5_wr_cnt", wr_burst_cnt, 1);
    // reset mid-burst, errors, clr, clean burst
    awvalid = 1; awready = 1; awlen = 3; step(); idle();
    wvalid = 1; wready = 1; step(); step(); idle();
    reset = 1; step(); reset = 0;
    chk("p6_reset_cnt", wr_burst_cnt, 0);
    chk("p6_reset_outst", wr_outst, 0);
    step();
    bvalid = 1; bready = 1; step(); idle();
    clr = 1; step(); idle();
    chk("p6_clr_err", err_vec, 0);
    awvalid = 1; awready = 1; awlen = 1; step(); idle();
    wvalid = 1; wready = 1; step(); wlast = 1; step(); idle();
    bvalid = 1; bready = 1; step(); idle();
    chk("p6_clean_cnt", wr_burst_cnt, 1);
    chk("p6_clean_err", err_vec, 0);
    // random traffic
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 599) == 0);
      clr = ($urandom_range(0, 79) == 0);
      if (!aw_st || $urandom_range(0, 15) == 0) begin
        awaddr = $urandom; awlen = 8'($urandom_range(0, 3));
        awsize = 3'($urandom_range(0, 7)); awburst = 2'($urandom_range(0, 2));
      end
      awvalid = aw_st ? ($urandom_range(0, 15) != 0) : 1'($urandom_range(0, 1));
      awready = 1'($urandom_range(0, 1));
      if (!w_st || $urandom_range(0, 15) == 0) begin
        wdata = $urandom; wstrb = 4'($urandom_range(0, 15));
        wlast = (wbeat == ((awq.size() > 0) ? awq[0] : int'(awlen))) ^ ($urandom_range(0, 15) == 0);
      end
      wvalid = w_st ? ($urandom_range(0, 15) != 0) : (awq.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      wready = 1'($urandom_range(0, 1));
      bresp = 2'($urandom_range(0, 3));
      bvalid = (pend > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
      bready = 1'($urandom_range(0, 1));
      if (!ar_st || $urandom_range(0, 15) == 0) begin
        araddr = $urandom; arlen = 8'($urandom_range(0, 3));
        arsize = 3'($urandom_range(0, 7)); arburst = 2'($urandom_range(0, 2));
      end
      arvalid = ar_st ? ($urandom_range(0, 15) != 0) : 1'($urandom_range(0, 1));
      arready = 1'($urandom_range(0, 1));
      rdata = $urandom; rresp = 2'($urandom_range(0, 3));
      rlast = (rbeat == ((arq.size() > 0) ? arq[0] : int'(arlen))) ^ ($urandom_range(0, 15) == 0);
      rvalid = (arq.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      rready = 1'($urandom_range(0, 1));
      step();
    end
    reset = 0; idle(); step();
    @(posedge clk); #2;
    chk("scoreboard_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
